rx_spatial_cb: RTL and testbench
================================

Name: rx_spatial_cb

Overview:
- Receive-side counterpart of the transmit spatial channel-bonding stage.
- Accepts N_CHANNEL per-lane streams, each carrying one lane-width slice, a byte count and a lane tlast, from the per-channel RX datapaths.
- Absorbs inter-lane skew in per-lane FIFOs and re-merges aligned slices into one wide AXI-Stream beat with tkeep reconstructed.
- Feeds the user-facing RX AXI-Stream interface.

Parameters:
- DWIDTH_IN, 240: per-lane data width in bits; multiple of 8; DWIDTH_IN/8 ≤ 255.
- DWIDTH_OUT, 240: merged output width; must equal N_CHANNEL*DWIDTH_IN.
- N_CHANNEL, 1: number of bonded lanes.
- FIFO_DEPTH, 8: per-lane skew FIFO depth; power of 2, ≥ 2.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- s_axis_tdata  in  [DWIDTH_IN-1:0] x N_CHANNEL  per-lane slice.
- s_axis_byte_cnt  in  [7:0] x N_CHANNEL  valid bytes in the slice, counted from the slice MSB.
- s_axis_tlast  in  N_CHANNEL  lane carries the final slice of a packet.
- s_axis_tvalid  in  N_CHANNEL  per-lane valid.
- s_axis_tready  out  N_CHANNEL  per-lane ready; lane i is ready when FIFO i is not full.
- m_axis_tdata  out  DWIDTH_OUT  merged beat; lane i occupies bits [(i+1)*DWIDTH_IN-1 -: DWIDTH_IN].
- m_axis_tkeep  out  DWIDTH_OUT/8  byte enables.
- m_axis_tlast  out  1  end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- lane_err  out  1  sticky framing error flag.

Behaviour:
- Reset (rst_n=0, asynchronous): all FIFOs empty, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, lane_err=0, s_axis_tready=0.
  - s_axis_tready rises on the first clk edge after deassertion.
  - Reset mid-packet discards all buffered slices with no partial output.
- Lane write: FIFO i pushes {tdata, byte_cnt, tlast} when s_axis_tvalid[i] & s_axis_tready[i]. Lanes are fully independent on input.
- Beat assembly, combinational over the FIFO heads:
  - Scan descending from lane N_CHANNEL-1.
  - The participating set is lanes N_CHANNEL-1 down to k, where k is the first lane scanned whose head has tlast=1, or lane 0 if none has.
  - Heads are examined in scan order; a lane whose FIFO is empty stops the scan and the beat is not ready.
  - Beat ready only when every participating lane is non-empty.
- Pop: when the beat is ready and the output register is empty or m_axis_tready=1, the following happen in the same cycle:
  - all participating FIFOs pop together;
  - the output register loads;
  - lanes below k are untouched; their heads start the next beat.
- Output register contents:
  - Participating lane i: tdata = head data; tkeep slice has its upper byte_cnt bits set. byte_cnt ≥ DWIDTH_IN/8 gives all ones; byte_cnt 0 gives all zeros.
  - Non-participating lanes: tdata=0, tkeep=0.
  - m_axis_tlast = 1 iff k was set by a tlast head.
- Output handshake: output is a single register stage.
  - Holds data while m_axis_tvalid & ~m_axis_tready.
  - Drops m_axis_tvalid after the transfer if no new beat is ready.
  - Back-to-back beats at full rate when ready stays high.
- Latency: 2 cycles from the write of the last-arriving participating slice to m_axis_tvalid=1 (FIFO write, then output load).
- FIFO full: s_axis_tready[i]=0. A simultaneous push and pop on a full FIFO is not accepted; ready is registered from the occupancy count.
- Pointer wrap-around uses log2(FIFO_DEPTH)-bit pointers plus an occupancy counter.
- lane_err is set, and stays set until reset, when a beat pops with a participating head that has tlast=0 and byte_cnt ≠ DWIDTH_IN/8. Data still forwards unchanged.
- N_CHANNEL=1: the block degenerates to a FIFO plus tkeep expansion.

Test Plan:
All scenarios use N_CHANNEL=4, DWIDTH_IN=32, DWIDTH_OUT=128, FIFO_DEPTH=8.
1. Aligned beat: all 4 lanes valid in the same cycle, byte_cnt=4, tlast=0, data 0xDDDDDDDD/0xCCCCCCCC/0xBBBBBBBB/0xAAAAAAAA on lanes 3..0 -> 2 cycles later tvalid=1, tdata=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, tkeep=16'hFFFF, tlast=0.
2. Skew: lanes 0-2 written at cycle 0, lane 3 at cycle 3 -> tvalid stays 0 through cycle 4; tvalid=1 at cycle 5 with a correctly merged beat.
3. Short last beat: lane3 byte_cnt=4, lane2 byte_cnt=2 with tlast=1; lanes 1/0 then carry the next packet's first beat -> first output tkeep=16'hFC00, tlast=1, bits[63:0]=0; the next packet's beat merges correctly afterwards.
4. Backpressure: m_axis_tready=0, 10 full beats offered -> each s_axis_tready drops after 8 FIFO entries plus 1 registered beat; release m_axis_tready -> 9 beats out in order, then the remaining 1, no loss or duplication.
5. Error: lane3 head byte_cnt=3, tlast=0 -> beat is forwarded with tkeep[15:12]=4'b1110 and lane_err=1, which holds through 20 later good beats.
6. Reset mid-burst: assert rst_n=0 between clk edges while 3 beats are buffered -> tvalid/tdata/tkeep/tlast/lane_err read 0 immediately; after release no stale beat appears and a new aligned beat passes with 2-cycle latency.

Source files
------------

// File: rtl/rx_spatial_cb.sv
// rx_spatial_cb
//   Receive-side spatial channel-bonding merge. Each of N_CHANNEL lanes delivers
//   one DWIDTH_IN slice per transfer into its own skew FIFO. Slices are merged
//   from the FIFO heads into one DWIDTH_OUT AXI-Stream beat, and tkeep is rebuilt
//   from the per-slice byte counts.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_tdata[i]     lane i slice
//   s_axis_byte_cnt[i]  valid bytes in lane i slice, counted from the slice MSB
//   s_axis_tlast[i]     lane i slice is the final slice of a packet
//   s_axis_tvalid[i]    lane i valid
//   s_axis_tready[i]    lane i ready (registered; low when FIFO i is full)
//   m_axis_*            merged output stream, single register stage
//   lane_err            sticky framing error flag
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. Valid never depends on ready. The output holds its payload while
// valid is high and ready is low.
module rx_spatial_cb #(
    parameter int DWIDTH_IN  = 240,
    parameter int DWIDTH_OUT = 240,
    parameter int N_CHANNEL  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_CHANNEL-1:0][DWIDTH_IN-1:0] s_axis_tdata,
    input  logic [N_CHANNEL-1:0][7:0]           s_axis_byte_cnt,
    input  logic [N_CHANNEL-1:0]                s_axis_tlast,
    input  logic [N_CHANNEL-1:0]                s_axis_tvalid,
    output logic [N_CHANNEL-1:0]                s_axis_tready,
    output logic [DWIDTH_OUT-1:0]               m_axis_tdata,
    output logic [DWIDTH_OUT/8-1:0]             m_axis_tkeep,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                lane_err
);

    localparam int NB = DWIDTH_IN / 8;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = DWIDTH_IN + 9;  // {data, byte_cnt, tlast}
    localparam int KW = DWIDTH_OUT / 8;

    // Per-lane skew FIFO storage and pointers
    logic [EW-1:0]                  mem_q [N_CHANNEL][FIFO_DEPTH];
    logic [N_CHANNEL-1:0][PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [N_CHANNEL-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [N_CHANNEL-1:0]           in_rdy_q, in_rdy_d;
    logic [N_CHANNEL-1:0]           push, pop;

    // FIFO heads
    logic [N_CHANNEL-1:0][DWIDTH_IN-1:0] head_data;
    logic [N_CHANNEL-1:0][7:0]           head_cnt;
    logic [N_CHANNEL-1:0]                head_last;

    // Beat assembly
    logic [N_CHANNEL-1:0] part;
    logic [N_CHANNEL-1:0] frame_bad;
    logic                 beat_rdy, beat_last, scan_stop, load;

    // Output register stage
    logic [DWIDTH_OUT-1:0] tdata_q, tdata_d;
    logic [KW-1:0]         tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;
    logic                  err_q, err_d;

    always_comb begin
        for (int i = 0; i < N_CHANNEL; i++) begin
            {head_data[i], head_cnt[i], head_last[i]} = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Scan from the top lane down. The first head carrying tlast closes the
    // beat; an empty lane met before that means the beat is not complete yet.
    always_comb begin
        part      = '0;
        beat_rdy  = 1'b1;
        beat_last = 1'b0;
        scan_stop = 1'b0;
        for (int i = N_CHANNEL - 1; i >= 0; i--) begin
            if (!scan_stop) begin
                if (cnt_q[i] == '0) begin
                    beat_rdy  = 1'b0;
                    scan_stop = 1'b1;
                end else begin
                    part[i] = 1'b1;
                    if (head_last[i]) begin
                        beat_last = 1'b1;
                        scan_stop = 1'b1;
                    end
                end
            end
        end
    end

    assign load = beat_rdy & (~tvalid_q | m_axis_tready);

    always_comb begin
        for (int i = 0; i < N_CHANNEL; i++) begin
            push[i]      = s_axis_tvalid[i] & in_rdy_q[i];
            pop[i]       = load & part[i];
            wr_ptr_d[i]  = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i]  = rd_ptr_q[i] + PW'(pop[i]);
            cnt_d[i]     = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            // Ready follows the next occupancy, so a full FIFO never sees a push.
            in_rdy_d[i]  = (cnt_d[i] != CW'(FIFO_DEPTH));
            frame_bad[i] = part[i] & ~head_last[i] & (head_cnt[i] != 8'(NB));
        end
    end

    always_comb begin
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        err_d    = err_q | (load & (|frame_bad));
        if (load) begin
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = beat_last;
            tvalid_d = 1'b1;
            for (int i = 0; i < N_CHANNEL; i++) begin
                if (part[i]) begin
                    tdata_d[i*DWIDTH_IN +: DWIDTH_IN] = head_data[i];
                    // Byte b (0 = LSB) is kept when it lies within the top byte_cnt bytes.
                    for (int b = 0; b < NB; b++) begin
                        tkeep_d[i*NB + b] = (head_cnt[i] > 8'(NB - 1 - b));
                    end
                end
            end
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Storage needs no reset; the pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CHANNEL; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {s_axis_tdata[i], s_axis_byte_cnt[i], s_axis_tlast[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            in_rdy_q <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            in_rdy_q <= in_rdy_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            err_q    <= err_d;
        end
    end

    assign s_axis_tready = in_rdy_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign lane_err      = err_q;

endmodule

// File: tb/tb_rx_spatial_cb.sv
module tb_rx_spatial_cb;

    localparam int N  = 4;
    localparam int DI = 32;
    localparam int DO = 128;
    localparam int FD = 8;
    localparam int W  = 146;  // {err, last, keep[15:0], data[127:0]}

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  cnt;
        logic        last;
    } slice_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][DI-1:0] s_tdata = '0;
    logic [N-1:0][7:0]    s_cnt = '0;
    logic [N-1:0]         s_tlast = '0;
    logic [N-1:0]         s_tvalid = '0;
    logic [N-1:0]         s_tready;
    logic [DO-1:0]        m_tdata;
    logic [DO/8-1:0]      m_tkeep;
    logic                 m_tlast, m_tvalid, lane_err;
    logic                 m_tready = 1'b0;

    rx_spatial_cb #(.DWIDTH_IN(DI), .DWIDTH_OUT(DO), .N_CHANNEL(N), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_byte_cnt(s_cnt), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .lane_err(lane_err)
    );

    // ---------------- state ----------------
    slice_t       stim_q [N][$];   // slices waiting to be offered per lane
    slice_t       lq [N][$];       // model of accepted slices per lane
    logic [W-1:0] exp_q[$];        // expected output beats
    logic         model_err = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_acc_cyc = 0;
    int           acc_cnt [N];
    int           rdy_mode = 0;    // 0 low, 1 high, 2 random
    bit           gap_en = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Forms every complete beat available from the accepted slices.
    task automatic model_assemble();
        bit go;
        bit ok;
        int k, lo, c;
        logic [127:0] d;
        logic [15:0]  kp;
        slice_t       s;
        go = 1;
        while (go) begin
            ok = 1;
            k = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (lq[i].size() == 0) begin
                    ok = 0;
                    break;
                end
                if (lq[i][0].last) begin
                    k = i;
                    break;
                end
            end
            if (!ok) begin
                go = 0;
            end else begin
                lo = (k < 0) ? 0 : k;
                d = '0;
                kp = '0;
                for (int i = N - 1; i >= lo; i--) begin
                    s = lq[i].pop_front();
                    d[i*32 +: 32] = s.data;
                    c = (s.cnt > 8'd4) ? 4 : int'(s.cnt);
                    kp[i*4 +: 4] = 4'(((1 << c) - 1) << (4 - c));
                    if (!s.last && s.cnt != 8'd4) model_err = 1'b1;
                end
                exp_q.push_back({model_err, (k >= 0), kp, d});
            end
        end
    endtask

    // ---------------- driver ----------------
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (stim_q[i].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i]  = stim_q[i][0].data;
                s_cnt[i]    = stim_q[i][0].cnt;
                s_tlast[i]  = stim_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
            end
        end
        case (rdy_mode)
            0: m_tready = 1'b0;
            1: m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- acceptance tracking + monitor ----------------
    logic [W-1:0] e;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    lq[i].push_back(stim_q[i].pop_front());
                    acc_cnt[i]++;
                    last_acc_cyc = cyc;
                end
            end
            model_assemble();
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", W'(m_tdata), '0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", W'(m_tdata), W'(e[127:0]));
                    check("beat_keep", W'(m_tkeep), W'(e[143:128]));
                    check("beat_last", W'(m_tlast), W'(e[144]));
                    check("beat_err", W'(lane_err), W'(e[145]));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_slice(input int lane, input logic [31:0] data, input logic [7:0] cnt, input logic last);
        slice_t s;
        s.data = data;
        s.cnt = cnt;
        s.last = last;
        stim_q[lane].push_back(s);
    endtask

    task automatic push_full_beat();
        for (int i = N - 1; i >= 0; i--) push_slice(i, $urandom, 8'd4, 1'b0);
    endtask

    function automatic int pending();
        int p;
        p = exp_q.size();
        for (int i = 0; i < N; i++) p += stim_q[i].size() + lq[i].size();
        return p;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (pending() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, W'(pending()), '0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!m_tvalid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, W'(m_tvalid), W'(1));
    endtask

    task automatic check_latency(input string name);
        check(name, W'(cyc - last_acc_cyc), W'(2));
    endtask

    // ---------------- sequence ----------------
    int base [N];
    int kk;
    bit hl;

    initial begin
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        #12;
        check("rst_tvalid", W'(m_tvalid), '0);
        check("rst_tdata", W'(m_tdata), '0);
        check("rst_tkeep", W'(m_tkeep), '0);
        check("rst_lane_err", W'(lane_err), '0);
        check("rst_s_tready", W'(s_tready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        check("tready_rise", W'(s_tready), W'(4'hF));

        // 1. aligned beat
        push_slice(3, 32'hDDDDDDDD, 8'd4, 1'b0);
        push_slice(2, 32'hCCCCCCCC, 8'd4, 1'b0);
        push_slice(1, 32'hBBBBBBBB, 8'd4, 1'b0);
        push_slice(0, 32'hAAAAAAAA, 8'd4, 1'b0);
        wait_valid("t1_valid", 20);
        check_latency("t1_latency");
        check("t1_tdata", W'(m_tdata), W'(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA));
        check("t1_tkeep", W'(m_tkeep), W'(16'hFFFF));
        check("t1_tlast", W'(m_tlast), '0);
        drain("t1_drain");

        // 2. skew: lane 3 arrives three cycles late
        push_slice(2, 32'h33333333, 8'd4, 1'b0);
        push_slice(1, 32'h22222222, 8'd4, 1'b0);
        push_slice(0, 32'h11111111, 8'd4, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("t2_hold", W'(m_tvalid), '0);
        end
        push_slice(3, 32'h44444444, 8'd4, 1'b0);
        wait_valid("t2_valid", 20);
        check_latency("t2_latency");
        check("t2_tdata", W'(m_tdata), W'(128'h44444444_33333333_22222222_11111111));
        drain("t2_drain");

        // 3. short last beat, next packet starts on lanes 1/0
        push_slice(3, 32'hA3A3A3A3, 8'd4, 1'b0);
        push_slice(2, 32'hA2A2A2A2, 8'd2, 1'b1);
        push_slice(1, 32'hB1B1B1B1, 8'd4, 1'b0);
        push_slice(0, 32'hB0B0B0B0, 8'd4, 1'b0);
        push_slice(3, 32'hB3B3B3B3, 8'd4, 1'b0);
        push_slice(2, 32'hB2B2B2B2, 8'd4, 1'b0);
        wait_valid("t3_valid", 20);
        check("t3_tkeep", W'(m_tkeep), W'(16'hFC00));
        check("t3_tlast", W'(m_tlast), W'(1));
        check("t3_low_zero", W'(m_tdata[63:0]), '0);
        drain("t3_drain");

        // 4. backpressure
        rdy_mode = 0;
        for (int i = 0; i < N; i++) base[i] = acc_cnt[i];
        repeat (10) push_full_beat();
        repeat (30) @(negedge clk);
        for (int i = 0; i < N; i++) check("t4_accepted9", W'(acc_cnt[i] - base[i]), W'(9));
        check("t4_tready_low", W'(s_tready), '0);
        check("t4_out_held", W'(m_tvalid), W'(1));
        rdy_mode = 1;
        drain("t4_drain");
        for (int i = 0; i < N; i++) check("t4_accepted10", W'(acc_cnt[i] - base[i]), W'(10));

        // random legal traffic with skew and random backpressure
        rdy_mode = 2;
        gap_en = 1;
        repeat (40) begin
            hl = 1'($urandom_range(0, 1));
            kk = hl ? int'($urandom_range(0, 3)) : 0;
            for (int i = N - 1; i >= kk; i--) begin
                if (hl && i == kk) push_slice(i, $urandom, 8'($urandom_range(0, 6)), 1'b1);
                else push_slice(i, $urandom, 8'd4, 1'b0);
            end
        end
        drain("rand_drain");
        check("rand_no_err", W'(lane_err), '0);
        gap_en = 0;
        rdy_mode = 1;

        // 5. framing error
        push_slice(3, 32'hE3E3E3E3, 8'd3, 1'b0);
        push_slice(2, 32'hE2E2E2E2, 8'd4, 1'b0);
        push_slice(1, 32'hE1E1E1E1, 8'd4, 1'b0);
        push_slice(0, 32'hE0E0E0E0, 8'd4, 1'b0);
        wait_valid("t5_valid", 20);
        check("t5_keep_hi", W'(m_tkeep[15:12]), W'(4'b1110));
        check("t5_err_set", W'(lane_err), W'(1));
        repeat (20) push_full_beat();
        drain("t5_drain");
        check("t5_err_sticky", W'(lane_err), W'(1));

        // 6. reset mid-burst
        rdy_mode = 0;
        repeat (3) push_full_beat();
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            stim_q[i].delete();
            lq[i].delete();
        end
        exp_q.delete();
        model_err = 1'b0;
        #1;
        check("t6_tvalid", W'(m_tvalid), '0);
        check("t6_tdata", W'(m_tdata), '0);
        check("t6_tkeep", W'(m_tkeep), '0);
        check("t6_tlast", W'(m_tlast), '0);
        check("t6_lane_err", W'(lane_err), '0);
        check("t6_s_tready", W'(s_tready), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        repeat (4) begin
            @(negedge clk);
            check("t6_no_stale", W'(m_tvalid), '0);
        end
        push_slice(3, 32'h76543210, 8'd4, 1'b0);
        push_slice(2, 32'hFEDCBA98, 8'd4, 1'b0);
        push_slice(1, 32'h01234567, 8'd4, 1'b0);
        push_slice(0, 32'h89ABCDEF, 8'd4, 1'b0);
        wait_valid("t6_valid", 20);
        check_latency("t6_latency");
        check("t6_tdata_new", W'(m_tdata), W'(128'h76543210_FEDCBA98_01234567_89ABCDEF));
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
